// File: rtl/battleship_pkg.sv
// battleship_pkg: shared states, board geometry and cell helpers for the battleship boards
package battleship_pkg;
  typedef enum logic [2:0] {PC_PLACE, PLAYER_PLACE, PLAYER_TURN, PC_TURN, WIN, LOSE} state_t;
  localparam int GRID = 5;
  localparam int CELL_W = 2;
  localparam int SHOT_OFS = 0;
  localparam int BOAT_OFS = 1;
  localparam int BOARD_W = GRID * GRID * CELL_W;
  function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return 6'(row) * 6'(GRID * CELL_W) + 6'(col) * 6'(CELL_W);
  endfunction
  function automatic logic [BOARD_W-1:0] boat_mask(input logic [2:0] row, input logic [2:0] col,
                                                   input logic [2:0] len);
    logic [BOARD_W-1:0] m;
    logic [3:0] c;
    m = '0;
    for (int i = 0; i < GRID; i++) begin
      c = {1'b0, col} + 4'(i);
      if (4'(i) < {1'b0, len} && c < 4'(GRID)) m[cell_idx(row, c[2:0]) + 6'(BOAT_OFS)] = 1'b1;
    end
    return m;
  endfunction
endpackage

// File: rtl/lfsr_aleatorio.sv
// lfsr_aleatorio: 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the PC random source
module lfsr_aleatorio #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] o_state
);
  logic [7:0] r_q;
  // shift left, feeding back the XOR of taps 8,6,5,4
  always_ff @(posedge clk)
    if (rst) r_q <= SEED;
    else r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
  assign o_state = r_q;
endmodule

// File: rtl/controlador_tablero.sv
// controlador_tablero: battleship game-state writer for player and PC 5x5 boards
module controlador_tablero
  import battleship_pkg::*;
#(
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter logic [31:0] PC_DELAY  = 32'd25_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  input  logic [2:0]          num_boats,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_fire,
  output logic [BOARD_W-1:0]  array_player,
  output logic [BOARD_W-1:0]  array_pc,
  output logic [4:0]          select_row,
  output logic [4:0]          select_col,
  output logic [4:0]          boat_row,
  output logic [4:0]          boat_col,
  output logic [2:0]          amount_boats,
  output logic                win,
  output logic                lose
);
  state_t r_state, w_state;
  logic [BOARD_W-1:0] r_player, w_player, r_pc, w_pc, w_pc_mask, w_pl_mask;
  logic [2:0] r_n, w_n, w_n_in, r_len, w_len, r_amount, w_amount;
  logic [2:0] r_sel_row, w_sel_row, r_sel_col, w_sel_col;
  logic [2:0] r_boat_row, w_boat_row, r_boat_col, w_boat_col;
  logic [2:0] w_rnd_row, w_place_col, w_shot_col, w_max_col, w_next_max;
  logic [3:0] r_pc_hits, w_pc_hits, r_player_hits, w_player_hits, w_total, w_pc_inc, w_pl_inc;
  logic [5:0] w_prod, w_sel_idx, w_shot_idx;
  logic [31:0] r_cnt, w_cnt;
  logic r_win, w_win, r_lose, w_lose;
  logic [7:0] w_lfsr;

  lfsr_aleatorio #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .o_state(w_lfsr));

  assign w_n_in      = num_boats == 3'd0 ? 3'd1 : (num_boats > 3'd5 ? 3'd5 : num_boats);
  assign w_prod      = {3'b0, r_n} * ({3'b0, r_n} + 6'd1);
  assign w_total     = 4'(w_prod >> 1);
  assign w_rnd_row   = 3'(w_lfsr % 8'd5);
  assign w_place_col = 3'(w_lfsr[7:4] % (4'd6 - {1'b0, r_len}));
  assign w_shot_col  = 3'(w_lfsr[7:4] % 4'd5);
  assign w_max_col   = 3'd5 - r_len;
  assign w_next_max  = 3'd4 - r_len;
  assign w_pc_mask   = boat_mask(w_rnd_row, w_place_col, r_len);
  assign w_pl_mask   = boat_mask(r_boat_row, r_boat_col, r_len);
  assign w_sel_idx   = cell_idx(r_sel_row, r_sel_col);
  assign w_shot_idx  = cell_idx(w_rnd_row, w_shot_col);
  assign w_pc_inc    = r_pc_hits + 4'(r_pc[w_sel_idx + 6'(BOAT_OFS)]);
  assign w_pl_inc    = r_player_hits + 4'(r_player[w_shot_idx + 6'(BOAT_OFS)]);

  // next state and board/cursor updates; at most one action per cycle, fire > up > down > left > right
  always_comb begin
    w_state       = r_state;
    w_n           = r_n;
    w_len         = r_len;
    w_amount      = r_amount;
    w_player      = r_player;
    w_pc          = r_pc;
    w_sel_row     = r_sel_row;
    w_sel_col     = r_sel_col;
    w_boat_row    = r_boat_row;
    w_boat_col    = r_boat_col;
    w_pc_hits     = r_pc_hits;
    w_player_hits = r_player_hits;
    w_cnt         = r_cnt;
    w_win         = r_win;
    w_lose        = r_lose;
    if (restart) begin
      w_state       = PC_PLACE;
      w_n           = w_n_in;
      w_len         = 3'd1;
      w_amount      = '0;
      w_player      = '0;
      w_pc          = '0;
      w_sel_row     = '0;
      w_sel_col     = '0;
      w_boat_row    = '0;
      w_boat_col    = '0;
      w_pc_hits     = '0;
      w_player_hits = '0;
      w_cnt         = '0;
      w_win         = 1'b0;
      w_lose        = 1'b0;
    end else begin
      case (r_state)
        PC_PLACE: begin
          if (~|(w_pc_mask & r_pc)) begin
            w_pc  = r_pc | w_pc_mask;
            w_len = r_len == r_n ? 3'd1 : r_len + 3'd1;
            if (r_len == r_n) begin
              w_state    = PLAYER_PLACE;
              w_amount   = 3'd1;
              w_boat_row = '0;
              w_boat_col = '0;
            end
          end
        end
        PLAYER_PLACE: begin
          if (btn_fire) begin
            if (~|(w_pl_mask & r_player)) begin
              w_player = r_player | w_pl_mask;
              if (r_len == r_n) begin
                w_state   = PLAYER_TURN;
                w_amount  = '0;
                w_sel_row = '0;
                w_sel_col = '0;
              end else begin
                w_len      = r_len + 3'd1;
                w_amount   = r_len + 3'd1;
                w_boat_col = r_boat_col > w_next_max ? w_next_max : r_boat_col;
              end
            end
          end
          else if (btn_up)    w_boat_row = r_boat_row == 3'd0 ? 3'd0 : r_boat_row - 3'd1;
          else if (btn_down)  w_boat_row = r_boat_row == 3'd4 ? 3'd4 : r_boat_row + 3'd1;
          else if (btn_left)  w_boat_col = r_boat_col == 3'd0 ? 3'd0 : r_boat_col - 3'd1;
          else if (btn_right) w_boat_col = r_boat_col >= w_max_col ? w_max_col : r_boat_col + 3'd1;
        end
        PLAYER_TURN: begin
          if (btn_fire) begin
            if (!r_pc[w_sel_idx + 6'(SHOT_OFS)]) begin
              w_pc[w_sel_idx + 6'(SHOT_OFS)] = 1'b1;
              w_pc_hits = w_pc_inc;
              w_state   = w_pc_inc == w_total ? WIN : PC_TURN;
              w_win     = w_pc_inc == w_total;
              w_cnt     = '0;
            end
          end
          else if (btn_up)    w_sel_row = r_sel_row == 3'd0 ? 3'd0 : r_sel_row - 3'd1;
          else if (btn_down)  w_sel_row = r_sel_row == 3'd4 ? 3'd4 : r_sel_row + 3'd1;
          else if (btn_left)  w_sel_col = r_sel_col == 3'd0 ? 3'd0 : r_sel_col - 3'd1;
          else if (btn_right) w_sel_col = r_sel_col == 3'd4 ? 3'd4 : r_sel_col + 3'd1;
        end
        PC_TURN: begin
          if (r_cnt < PC_DELAY) w_cnt = r_cnt + 32'd1;
          else if (!r_player[w_shot_idx + 6'(SHOT_OFS)]) begin
            w_player[w_shot_idx + 6'(SHOT_OFS)] = 1'b1;
            w_player_hits = w_pl_inc;
            w_state       = w_pl_inc == w_total ? LOSE : PLAYER_TURN;
            w_lose        = w_pl_inc == w_total;
          end
        end
        default: ;
      endcase
    end
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= PC_PLACE;
      r_n           <= w_n_in;
      r_len         <= 3'd1;
      r_amount      <= '0;
      r_player      <= '0;
      r_pc          <= '0;
      r_sel_row     <= '0;
      r_sel_col     <= '0;
      r_boat_row    <= '0;
      r_boat_col    <= '0;
      r_pc_hits     <= '0;
      r_player_hits <= '0;
      r_cnt         <= '0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_n           <= w_n;
      r_len         <= w_len;
      r_amount      <= w_amount;
      r_player      <= w_player;
      r_pc          <= w_pc;
      r_sel_row     <= w_sel_row;
      r_sel_col     <= w_sel_col;
      r_boat_row    <= w_boat_row;
      r_boat_col    <= w_boat_col;
      r_pc_hits     <= w_pc_hits;
      r_player_hits <= w_player_hits;
      r_cnt         <= w_cnt;
      r_win         <= w_win;
      r_lose        <= w_lose;
    end
  end

  assign array_player = r_player;
  assign array_pc     = r_pc;
  assign select_row   = {2'b0, r_sel_row};
  assign select_col   = {2'b0, r_sel_col};
  assign boat_row     = {2'b0, r_boat_row};
  assign boat_col     = {2'b0, r_boat_col};
  assign amount_boats = r_amount;
  assign win          = r_win;
  assign lose         = r_lose;
endmodule

// File: tb/tb_controlador_tablero.sv
// tb_controlador_tablero: directed table-driven checks of the battleship board controller
module tb_controlador_tablero;
  localparam logic [4:0] F = 5'b10000, U = 5'b01000, D = 5'b00100, L = 5'b00010, R = 5'b00001;
  localparam logic [49:0] ODD = 50'h2_AAAA_AAAA_AAAA;
  typedef struct {
    logic [4:0]  btn;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [2:0]  amt;
    logic [49:0] pl;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, restart = 1'b0;
  logic [2:0] num_boats = 3'd3;
  logic [4:0] btn = '0;
  logic [49:0] array_player, array_pc, pcb;
  logic [4:0] select_row, select_col, boat_row, boat_col;
  logic [2:0] amount_boats;
  logic win, lose;
  int n_cmp = 0, n_bad = 0;
  vec_t tv[$];

  controlador_tablero #(.LFSR_SEED(8'hA5), .PC_DELAY(32'd4)) dut (
    .clk(clk), .rst(rst), .restart(restart), .num_boats(num_boats),
    .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]), .btn_fire(btn[4]),
    .array_player(array_player), .array_pc(array_pc),
    .select_row(select_row), .select_col(select_col), .boat_row(boat_row), .boat_col(boat_col),
    .amount_boats(amount_boats), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    tick();
    btn = '0;
  endtask

  function automatic int ones(input logic [49:0] v, input int ofs);
    int n = 0;
    for (int i = 0; i < 25; i++) n += int'(v[2*i+ofs]);
    return n;
  endfunction

  function automatic vec_t mk(input logic [4:0] b, input int r, input int c, input int a, input logic [49:0] p);
    vec_t v;
    v.btn = b;
    v.row = 3'(r);
    v.col = 3'(c);
    v.amt = 3'(a);
    v.pl  = p;
    return v;
  endfunction

  task automatic wait_place(input string name);
    int n = 0;
    while (amount_boats !== 3'd1 && n < 256) begin
      tick();
      n++;
    end
    check(name, 64'(amount_boats), 64'd1);
  endtask

  task automatic do_restart(input logic [2:0] n);
    num_boats = n;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic check_reset(input string name);
    check({name, "_player"}, 64'(array_player), 64'd0);
    check({name, "_pc"}, 64'(array_pc), 64'd0);
    check({name, "_cursors"}, 64'({select_row, select_col, boat_row, boat_col}), 64'd0);
    check({name, "_amount"}, 64'(amount_boats), 64'd0);
    check({name, "_winlose"}, 64'({win, lose}), 64'd0);
  endtask

  initial begin
    int cyc;
    tv.push_back(mk(F, 0, 0, 2, 50'h2));
    tv.push_back(mk(U, 0, 0, 2, 50'h2));
    for (int r = 1; r <= 4; r++) tv.push_back(mk(D, r, 0, 2, 50'h2));
    tv.push_back(mk(D, 4, 0, 2, 50'h2));
    for (int r = 3; r >= 0; r--) tv.push_back(mk(U, r, 0, 2, 50'h2));
    tv.push_back(mk(L, 0, 0, 2, 50'h2));
    tv.push_back(mk(R, 0, 1, 2, 50'h2));
    tv.push_back(mk(R, 0, 2, 2, 50'h2));
    for (int i = 0; i < 7; i++) tv.push_back(mk(R, 0, 3, 2, 50'h2));
    tv.push_back(mk(D | R, 1, 3, 2, 50'h2));
    tv.push_back(mk(U | L, 0, 3, 2, 50'h2));
    tv.push_back(mk(F, 0, 3, 0, 50'h282));

    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    wait_place("pc_place_n3");
    check("pc_boats_n3", 64'(ones(array_pc, 1)), 64'd6);
    check("pc_shots_n3", 64'(ones(array_pc, 0)), 64'd0);

    do_restart(3'd2);
    check("restart_pc", 64'(array_pc), 64'd0);
    wait_place("pc_place_n2");
    for (int i = 0; i < tv.size(); i++) begin
      press(tv[i].btn);
      check($sformatf("tv%0d_row", i), 64'(boat_row), 64'(tv[i].row));
      check($sformatf("tv%0d_col", i), 64'(boat_col), 64'(tv[i].col));
      check($sformatf("tv%0d_amt", i), 64'(amount_boats), 64'(tv[i].amt));
      check($sformatf("tv%0d_pl", i), 64'(array_player), 64'(tv[i].pl));
    end

    do_restart(3'd2);
    wait_place("pc_place_ovl");
    press(D); press(D); press(R); press(R); press(F);
    check("ovl_first", 64'(array_player), 64'h200_0000);
    check("ovl_amt2", 64'(amount_boats), 64'd2);
    press(L);
    check("ovl_col1", 64'(boat_col), 64'd1);
    press(F);
    check("ovl_reject_amt", 64'(amount_boats), 64'd2);
    check("ovl_reject_pl", 64'(array_player), 64'h200_0000);
    press(R); press(R);
    check("ovl_col3", 64'(boat_col), 64'd3);
    press(F);
    check("ovl_accept_pl", 64'(array_player), 64'h2A00_0000);
    check("ovl_accept_amt", 64'(amount_boats), 64'd0);
    check("turn_sel0", 64'({select_row, select_col}), 64'd0);

    press(D); press(R);
    check("turn_sel11", 64'({select_row, select_col}), {54'd0, 5'd1, 5'd1});
    pcb = array_pc;
    press(F);
    check("shot_12", 64'(array_pc[12]), 64'd1);
    check("shot_only12", 64'(array_pc ^ pcb), 64'h1000);
    press(R);
    check("pcturn_ignores_btn", 64'(select_col), 64'd1);
    cyc = 1;
    while (ones(array_player, 0) == 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("pc_one_shot", 64'(ones(array_player, 0)), 64'd1);
    check("pc_delay_min", 64'(cyc >= 4), 64'd1);
    check("pc_boats_kept", 64'(array_player & ODD), 64'h2A00_0000);
    pcb = array_pc;
    press(F);
    check("reshot_ignored", 64'(array_pc), 64'(pcb));
    for (int i = 0; i < 10; i++) tick();
    check("reshot_no_pcturn", 64'(ones(array_player, 0)), 64'd1);

    press(U);
    pcb = array_pc;
    press(F | R);
    check("fire_right_shot", 64'(array_pc ^ pcb), 64'h4);
    check("fire_right_cursor", 64'({select_row, select_col}), {54'd0, 5'd0, 5'd1});
    tick();
    tick();
    num_boats = 3'd1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("mid_pcturn_rst");

    tick();
    check("seed_layout", 64'(array_pc), 64'h2);
    check("seed_amt", 64'(amount_boats), 64'd1);
    press(F);
    check("win_pl_place", 64'(array_player), 64'h2);
    check("win_amt0", 64'(amount_boats), 64'd0);
    check("win_before", 64'(win), 64'd0);
    press(F);
    check("win_shot", 64'(array_pc), 64'h3);
    check("win_rise", 64'({win, lose}), 64'b10);
    press(R); press(D); press(F);
    for (int i = 0; i < 10; i++) tick();
    check("frozen_pc", 64'(array_pc), 64'h3);
    check("frozen_pl", 64'(array_player), 64'h2);
    check("frozen_sel", 64'({select_row, select_col}), 64'd0);
    check("frozen_winlose", 64'({win, lose}), 64'b10);
    do_restart(3'd1);
    check("restart_arrays", 64'({array_player[0], array_pc}), 64'd0);
    check("restart_pl", 64'(array_player), 64'd0);
    check("restart_win", 64'(win), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
